// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX serializer
// between N_REQ byte producers, with idle gap and start timeout.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [7:0]         tx_data_o,
  output logic               tx_start_o,
  input  logic               tx_busy_i,
  output logic [N_REQ-1:0]   grant_o,
  output logic               active_o,
  output logic               err_timeout_o
);

  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 0) ?
                      $clog2(GAP_CYCLES + 1) : 1;
  // Timeout fires on the edge where the count reaches
  // TIMEOUT_CYCLES-1, so the pulse lands TIMEOUT_CYCLES
  // cycles after the start pulse.
  localparam int TO_HIT = (TIMEOUT_CYCLES > 1) ?
                          TIMEOUT_CYCLES - 2 : 0;
  // Zero gap still spends one cycle in GAP.
  localparam int GAP_LAST = (GAP_CYCLES > 0) ?
                            GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;

  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic [PW-1:0] ptr_next;
  logic          found;
  logic          accept;
  logic [7:0]    win_data;

  // Rotating priority search starting at the pointer.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % N_REQ);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign accept = (state == IDLE) && !rst_i &&
                  !tx_busy_i && found;

  assign req_ready_o = accept ?
    ({{(N_REQ-1){1'b0}}, 1'b1} << win) : '0;

  assign win_data = req_data_i[{win, 3'b000} +: 8];

  assign ptr_next = (win == PW'(N_REQ - 1)) ?
                    '0 : win + PW'(1);

  // Frame sequencing FSM with registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      ptr           <= '0;
      tcnt          <= '0;
      gcnt          <= '0;
      tx_data_o     <= '0;
      tx_start_o    <= 1'b0;
      grant_o       <= '0;
      active_o      <= 1'b0;
      err_timeout_o <= 1'b0;
    end else begin
      tx_start_o    <= 1'b0;
      err_timeout_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            tx_data_o  <= win_data;
            grant_o    <= req_ready_o;
            ptr        <= ptr_next;
            tx_start_o <= 1'b1;
            active_o   <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          tcnt  <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy_i) begin
            state <= WAIT_DONE;
          end else if (tcnt == TW'(TO_HIT)) begin
            tcnt          <= tcnt + TW'(1);
            err_timeout_o <= 1'b1;
            gcnt          <= '0;
            state         <= GAP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy_i) begin
            gcnt  <= '0;
            state <= GAP;
          end
        end
        GAP: begin
          if (gcnt == GW'(GAP_LAST)) begin
            grant_o  <= '0;
            active_o <= 1'b0;
            state    <= IDLE;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple
// serializer busy model driven from tx_start.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [3:0]  grant;
  logic        active;
  logic        err_timeout;

  logic        force_busy = 1'b0;
  logic        busy_en = 1'b1;
  int          busy_len = 10;
  int          rem = 0;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(
    .N_REQ(4),
    .GAP_CYCLES(16),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(req_valid),
    .req_data_i(req_data),
    .req_ready_o(req_ready),
    .tx_data_o(tx_data),
    .tx_start_o(tx_start),
    .tx_busy_i(tx_busy),
    .grant_o(grant),
    .active_o(active),
    .err_timeout_o(err_timeout)
  );

  always #5 clk = ~clk;

  // Serializer model: busy for busy_len cycles after start.
  always @(posedge clk) begin
    if (busy_en && tx_start) rem <= busy_len;
    else if (rem > 0) rem <= rem - 1;
  end
  assign tx_busy = force_busy | (rem != 0);

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_accept(input int budget,
                             output int idx);
    idx = -1;
    for (int c = 0; c < budget; c++) begin
      if (req_ready != 4'b0) begin
        check("ready_onehot",
              {31'b0, $onehot(req_ready)}, 32'd1);
        for (int k = 0; k < 4; k++)
          if (req_ready[k]) idx = k;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int idx;
    int stc;
    int errk;
    int g;
    logic seen;
    logic [7:0] bytes [4];
    int ord2 [6];
    int ord3 [4];

    bytes[0] = 8'h11; bytes[1] = 8'h22;
    bytes[2] = 8'h33; bytes[3] = 8'h44;
    ord2[0] = 0; ord2[1] = 1; ord2[2] = 2;
    ord2[3] = 3; ord2[4] = 0; ord2[5] = 1;
    ord3[0] = 1; ord3[1] = 3;
    ord3[2] = 1; ord3[3] = 3;

    // Reset state
    #1;
    check("rst_tx_data", {24'b0, tx_data}, 0);
    check("rst_tx_start", {31'b0, tx_start}, 0);
    check("rst_grant", {28'b0, grant}, 0);
    check("rst_active", {31'b0, active}, 0);
    check("rst_err", {31'b0, err_timeout}, 0);
    check("rst_ready", {28'b0, req_ready}, 0);
    do_reset();

    // Test 1: single requester, 10-cycle frame
    busy_en = 1'b1;
    busy_len = 10;
    req_data = 32'h0000_00A5;
    req_valid = 4'b0001;
    #1;
    check("t1_ready", {28'b0, req_ready}, 32'h1);
    tick();
    check("t1_start", {31'b0, tx_start}, 1);
    check("t1_data", {24'b0, tx_data}, 32'hA5);
    check("t1_grant", {28'b0, grant}, 32'h1);
    check("t1_active", {31'b0, active}, 1);
    check("t1_ready_off", {28'b0, req_ready}, 0);
    req_valid = 4'b0000;
    tick();
    check("t1_start_once", {31'b0, tx_start}, 0);
    repeat (10) tick();
    repeat (16) tick();
    check("t1_gap_active", {31'b0, active}, 1);
    check("t1_gap_grant", {28'b0, grant}, 32'h1);
    tick();
    check("t1_idle_active", {31'b0, active}, 0);
    check("t1_idle_grant", {28'b0, grant}, 0);

    // Test 2: all requesters valid
    do_reset();
    busy_len = 3;
    req_data = 32'h4433_2211;
    req_valid = 4'b1111;
    #1;
    for (int i = 0; i < 6; i++) begin
      wait_accept(100, idx);
      check("t2_order", idx, ord2[i]);
      tick();
      check("t2_data", {24'b0, tx_data},
            {24'b0, bytes[idx & 3]});
      check("t2_start", {31'b0, tx_start}, 1);
    end
    req_valid = 4'b0000;
    repeat (30) tick();

    // Test 3: only requesters 1 and 3 valid
    do_reset();
    req_data = 32'h4433_2211;
    req_valid = 4'b1010;
    #1;
    for (int i = 0; i < 4; i++) begin
      wait_accept(100, idx);
      check("t3_order", idx, ord3[i]);
      tick();
      check("t3_data", {24'b0, tx_data},
            {24'b0, bytes[idx & 3]});
    end
    req_valid = 4'b0000;
    repeat (30) tick();

    // Test 4: engine never goes busy
    do_reset();
    busy_en = 1'b0;
    req_data = 32'h0000_2211;
    req_valid = 4'b0011;
    #1;
    wait_accept(10, idx);
    check("t4_first", idx, 0);
    tick();
    req_valid = 4'b0010;
    check("t4_start", {31'b0, tx_start}, 1);
    stc = 0;
    errk = -1;
    for (int k = 1; k <= 1100; k++) begin
      tick();
      if (tx_start) stc++;
      if (err_timeout) begin
        errk = k;
        break;
      end
    end
    check("t4_err_time", errk, 1024);
    check("t4_no_restart", stc, 0);
    tick();
    check("t4_err_pulse", {31'b0, err_timeout}, 0);
    g = 0;
    for (int c = 0; c < 40; c++) begin
      if (req_ready != 4'b0 || tx_start) break;
      tick();
      g++;
    end
    check("t4_gap_len", g, 15);
    wait_accept(5, idx);
    check("t4_next", idx, 1);
    tick();
    check("t4_next_data", {24'b0, tx_data}, 32'h22);
    req_valid = 4'b0000;
    repeat (1100) tick();

    // Test 5: reset during WAIT_DONE
    do_reset();
    busy_en = 1'b1;
    busy_len = 10;
    req_data = 32'h4433_2211;
    req_valid = 4'b0001;
    #1;
    wait_accept(10, idx);
    check("t5_first", idx, 0);
    tick();
    req_valid = 4'b0000;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check("t5_tx_data", {24'b0, tx_data}, 0);
    check("t5_start", {31'b0, tx_start}, 0);
    check("t5_grant", {28'b0, grant}, 0);
    check("t5_active", {31'b0, active}, 0);
    check("t5_err", {31'b0, err_timeout}, 0);
    check("t5_ready", {28'b0, req_ready}, 0);
    tick();
    rst = 1'b0;
    req_valid = 4'b1100;
    #1;
    wait_accept(60, idx);
    check("t5_grant_idx", idx, 2);
    tick();
    check("t5_grant_reg", {28'b0, grant}, 32'h4);
    check("t5_data", {24'b0, tx_data}, 32'h33);
    req_valid = 4'b0000;
    repeat (40) tick();

    // Test 6: busy held high while IDLE
    do_reset();
    busy_en = 1'b0;
    force_busy = 1'b1;
    req_data = 32'h0000_005A;
    req_valid = 4'b0001;
    #1;
    seen = 1'b0;
    repeat (6) begin
      if (req_ready != 4'b0 || tx_start) seen = 1'b1;
      tick();
    end
    check("t6_blocked", {31'b0, seen}, 0);
    force_busy = 1'b0;
    #1;
    check("t6_ready", {28'b0, req_ready}, 32'h1);
    tick();
    check("t6_start", {31'b0, tx_start}, 1);
    check("t6_data", {24'b0, tx_data}, 32'h5A);
    req_valid = 4'b0000;
    tick();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
